pgm_vram_arbiter: RTL and testbench
===================================

Name: pgm_vram_arbiter

Overview:
Shares one single-port video RAM (tilemap VRAM, 16-bit words) between the 68000 bus and the tilemap renderer.
- Renderer has default priority because it is real-time.
- A starvation counter guarantees the CPU a slot within STARVE_MAX denied cycles.
- Generates 68k DTACK, holds CPU read data, applies byte-lane write enables, and returns renderer read data with fixed latency.
- Sits between the 68k address decoder and the VRAM array.

Parameters:
AW, 13, word-address width of VRAM
STARVE_MAX, 4, max consecutive cycles a pending CPU access may be denied (1..15)

Ports:
fixed_20m_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
cpu_sel  in  1  68k VRAM select (decoded address qualified by AS), held until DTACK seen
cpu_rw_n  in  1  1=read, 0=write
cpu_uds_n  in  1  upper byte strobe, active low
cpu_lds_n  in  1  lower byte strobe, active low
cpu_addr  in  AW  word address
cpu_din  in  16  write data from 68k
cpu_dout  out  16  registered read data to 68k
cpu_dtack_n  out  1  registered DTACK, active low
rnd_req  in  1  renderer request; held with rnd_addr until rnd_ack
rnd_addr  in  AW  renderer word address
rnd_ack  out  1  combinational grant to renderer this cycle
rnd_valid  out  1  registered; rnd_data valid
rnd_data  out  16  equals ram_rdata; meaningful only when rnd_valid=1
ram_addr  out  AW  RAM address (combinational from grant)
ram_we  out  1  RAM write strobe
ram_be  out  2  byte enables {upper, lower}
ram_wdata  out  16  RAM write data
ram_rdata  in  16  RAM read data, valid the cycle after the address

Behaviour:
- State machine states:
  - S_IDLE: no access, or CPU waiting.
  - S_RD: read data-return cycle.
  - S_DONE: DTACK asserted.
- cpu_grant = S_IDLE & cpu_sel & (!rnd_req | starve_cnt >= STARVE_MAX). It is evaluated in the same cycle cpu_sel is first seen.
- rnd_ack = rnd_req & !cpu_grant. Exactly one requester owns the RAM port per cycle.
- On CPU grant:
  - ram_addr=cpu_addr.
  - ram_be={~cpu_uds_n, ~cpu_lds_n}.
  - Write: ram_we = |ram_be, ram_wdata=cpu_din, next state S_DONE.
  - Read: ram_we=0, next state S_RD.
- On rnd_ack: ram_addr=rnd_addr, ram_we=0, ram_be=2'b11.
- With no grant and no ack: ram_addr, ram_we, ram_be and ram_wdata are all 0.
- S_RD: cpu_dout <= ram_rdata; next state S_DONE.
- S_DONE: cpu_dtack_n=0 (registered from state). Stay until cpu_sel=0, then go to S_IDLE; cpu_dtack_n returns to 1 the following cycle.
- Latency, uncontended, grant in cycle T:
  - Write: dtack_n=0 at T+1.
  - Read: data captured end of T+1, dtack_n=0 at T+2.
- Renderer: rnd_valid <= rnd_ack. Read latency is 1 cycle from ack; back-to-back acks give one word per cycle.
- starve_cnt (4 bits):
  - Increments each cycle in S_IDLE with cpu_sel=1 and no grant, saturating at 15.
  - Clears on CPU grant and whenever cpu_sel=0.
- Write with both strobes high: no RAM write (ram_we=0), DTACK still returned.
- cpu_sel dropped while waiting (aborted cycle): no RAM operation, starve_cnt cleared, remain in S_IDLE.
- cpu_sel dropped in S_RD: the read completes. S_DONE is then entered and, because cpu_sel=0, exits the next cycle; DTACK pulses one cycle harmlessly.
- A new access cannot start until the state returns to S_IDLE, which requires cpu_sel low after DTACK.
- Reset values: cpu_dtack_n=1, cpu_dout=0, rnd_valid=0, state=S_IDLE, starve_cnt=0. Combinational outputs are 0 while reset=1 (rnd_ack=0, no RAM op).
- Reset mid-operation: the pending or in-progress access is abandoned. If cpu_sel is still high after reset release, it is treated as a new access.

Test Plan:
- Uncontended read: VRAM[0x0123]=0xBEEF, rnd_req=0, cpu_sel rises at T → ram_addr=0x0123 at T, cpu_dout=0xBEEF and dtack_n=0 at T+2, dtack_n=1 one cycle after cpu_sel falls.
- Byte write: cpu_din=0x1234, uds_n=0, lds_n=1 to word 0x10 holding 0xAAAA → ram_be=2'b10, ram_we=1 at T, word becomes 0x12AA, dtack_n=0 at T+1.
- Starvation (STARVE_MAX=4): rnd_req held high continuously, cpu_sel rises at T → rnd_ack=1 on T..T+3, CPU granted at T+4 with rnd_ack=0, rnd_ack=1 again at T+5.
- Renderer stream: rnd_req high 8 cycles on addresses 0..7, CPU idle → rnd_valid high 8 consecutive cycles starting 1 cycle after the first ack, rnd_data = VRAM[0..7] in order.
- Abort: cpu_sel high 2 cycles while starved (rnd_req=1), then low → ram_we never 1, dtack_n stays 1, starve_cnt=0.
- Reset during S_RD → next cycle dtack_n=1 and state=S_IDLE. cpu_sel held high through reset → a fresh grant occurs after release and the read completes normally.

Source files
------------

// File: rtl/pgm_vram_arbiter_if.sv
// pgm_vram_arbiter_if: 68k, renderer and VRAM port signals; slave = arbiter side, master = requesters/RAM side
interface pgm_vram_arbiter_if #(parameter int AW = 13);
  logic          cpu_sel;
  logic          cpu_rw_n;
  logic          cpu_uds_n;
  logic          cpu_lds_n;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [15:0]   cpu_dout;
  logic          cpu_dtack_n;
  logic          rnd_req;
  logic [AW-1:0] rnd_addr;
  logic          rnd_ack;
  logic          rnd_valid;
  logic [15:0]   rnd_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;
  modport slave (
    input  cpu_sel, cpu_rw_n, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_din, rnd_req, rnd_addr, ram_rdata,
    output cpu_dout, cpu_dtack_n, rnd_ack, rnd_valid, rnd_data, ram_addr, ram_we, ram_be, ram_wdata
  );
  modport master (
    output cpu_sel, cpu_rw_n, cpu_uds_n, cpu_lds_n, cpu_addr, cpu_din, rnd_req, rnd_addr, ram_rdata,
    input  cpu_dout, cpu_dtack_n, rnd_ack, rnd_valid, rnd_data, ram_addr, ram_we, ram_be, ram_wdata
  );
endinterface

// File: rtl/pgm_vram_arbiter.sv
// pgm_vram_arbiter: shares one VRAM port between 68k (DTACK, byte lanes, starvation guard) and renderer (default priority); ports: fixed_20m_clk, reset, bus (slave)
module pgm_vram_arbiter #(
  parameter int AW         = 13,
  parameter int STARVE_MAX = 4
) (
  input logic               fixed_20m_clk,
  input logic               reset,
  pgm_vram_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RD = 2'd1, S_DONE = 2'd2;
  logic [1:0] state, state_nxt;
  logic [3:0] starve_cnt;
  logic       cpu_grant, cpu_wr;
  assign cpu_wr       = !bus.cpu_rw_n;
  assign bus.rnd_data = bus.ram_rdata;
  always_comb begin
    cpu_grant     = !reset && state == S_IDLE && bus.cpu_sel && (!bus.rnd_req || starve_cnt >= 4'(STARVE_MAX));
    bus.rnd_ack   = !reset && bus.rnd_req && !cpu_grant;
    bus.ram_addr  = cpu_grant ? bus.cpu_addr : bus.rnd_ack ? bus.rnd_addr : {AW{1'b0}};
    bus.ram_be    = cpu_grant ? {~bus.cpu_uds_n, ~bus.cpu_lds_n} : bus.rnd_ack ? 2'b11 : 2'b00;
    bus.ram_we    = cpu_grant && cpu_wr && |bus.ram_be;
    bus.ram_wdata = cpu_grant && cpu_wr ? bus.cpu_din : 16'h0000;
    state_nxt     = cpu_grant ? (cpu_wr ? S_DONE : S_RD) :
                    state == S_RD ? S_DONE :
                    state == S_DONE && bus.cpu_sel ? S_DONE : S_IDLE;
  end
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      state           <= S_IDLE;
      starve_cnt      <= 4'd0;
      bus.cpu_dtack_n <= 1'b1;
      bus.cpu_dout    <= 16'h0000;
      bus.rnd_valid   <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.cpu_dtack_n <= state_nxt != S_DONE;
      bus.rnd_valid   <= bus.rnd_ack;
      if (state == S_RD) bus.cpu_dout <= bus.ram_rdata;
      starve_cnt      <= cpu_grant || !bus.cpu_sel ? 4'd0 :
                         state == S_IDLE && starve_cnt != 4'hf ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_pgm_vram_arbiter.sv
// tb_pgm_vram_arbiter: directed and randomized checks of the VRAM arbiter against a VRAM model and transaction-level reference
module tb_pgm_vram_arbiter;
  localparam int AW = 13;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] mem    [0:(1<<AW)-1];
  logic [15:0] shadow [0:(1<<AW)-1];
  always #25 clk = ~clk;
  pgm_vram_arbiter_if #(.AW(AW)) bus();
  pgm_vram_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
    .fixed_20m_clk(clk),
    .reset(rst),
    .bus(bus)
  );
  function automatic logic [15:0] init_val(input int i);
    return i == 'h123 ? 16'hBEEF : i == 'h10 ? 16'hAAAA : 16'(i * 40503 + 7);
  endfunction
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
    end else if (bus.ram_we) begin
      if (bus.ram_be[1]) mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_be[0]) mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic smp();
    @(negedge clk);
  endtask
  task automatic cpu_start(input logic wr, input logic uds_n, input logic lds_n, input logic [AW-1:0] a, input logic [15:0] d);
    bus.cpu_sel   = 1'b1;
    bus.cpu_rw_n  = !wr;
    bus.cpu_uds_n = uds_n;
    bus.cpu_lds_n = lds_n;
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
  endtask
  task automatic cpu_read(input string tag, input logic [AW-1:0] a, input logic [15:0] exp);
    cpu_start(1'b0, 1'b0, 1'b0, a, 16'h0);
    smp(); chk({tag, "_addr"}, bus.ram_addr, a);
    nxt(); smp(); chk({tag, "_dtk1"}, bus.cpu_dtack_n, 1);
    nxt(); smp(); chk({tag, "_dtk0"}, bus.cpu_dtack_n, 0); chk({tag, "_data"}, bus.cpu_dout, exp);
    nxt(); bus.cpu_sel = 1'b0; smp();
    nxt();
  endtask
  int ph, denied;
  logic wr, exp_ack, prev_ack, grant;
  logic [1:0] be;
  logic [AW-1:0] ca, prev_addr;
  logic [15:0] cd, exp_dout;
  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_val(i);
    bus.cpu_sel = 1'b0; bus.cpu_rw_n = 1'b1; bus.cpu_uds_n = 1'b1; bus.cpu_lds_n = 1'b1;
    bus.cpu_addr = '0; bus.cpu_din = '0; bus.rnd_req = 1'b1; bus.rnd_addr = AW'(5);
    nxt(); nxt();
    smp();
    chk("rst_dtack", bus.cpu_dtack_n, 1);
    chk("rst_dout", bus.cpu_dout, 0);
    chk("rst_valid", bus.rnd_valid, 0);
    chk("rst_ack", bus.rnd_ack, 0);
    chk("rst_be", bus.ram_be, 0);
    nxt();
    rst = 1'b0; mem_init = 1'b0; bus.rnd_req = 1'b0;
    nxt();
    cpu_start(1'b0, 1'b0, 1'b0, AW'('h123), 16'h0);
    smp(); chk("rd_addr", bus.ram_addr, 'h123); chk("rd_we", bus.ram_we, 0); chk("rd_dtk_t0", bus.cpu_dtack_n, 1);
    nxt(); smp(); chk("rd_dtk_t1", bus.cpu_dtack_n, 1);
    nxt(); smp(); chk("rd_dtk_t2", bus.cpu_dtack_n, 0); chk("rd_data", bus.cpu_dout, 16'hBEEF);
    nxt(); bus.cpu_sel = 1'b0;
    smp(); chk("rd_dtk_hold", bus.cpu_dtack_n, 0);
    nxt(); smp(); chk("rd_dtk_rel", bus.cpu_dtack_n, 1);
    nxt();
    cpu_start(1'b1, 1'b0, 1'b1, AW'('h10), 16'h1234);
    smp(); chk("bw_be", bus.ram_be, 2'b10); chk("bw_we", bus.ram_we, 1); chk("bw_wdata", bus.ram_wdata, 16'h1234);
    chk("bw_dtk_t0", bus.cpu_dtack_n, 1);
    nxt(); smp(); chk("bw_dtk_t1", bus.cpu_dtack_n, 0);
    nxt(); bus.cpu_sel = 1'b0; smp();
    nxt();
    shadow['h10] = 16'h12AA;
    cpu_read("bw_rb", AW'('h10), 16'h12AA);
    cpu_start(1'b1, 1'b1, 1'b1, AW'('h21), 16'hFFFF);
    smp(); chk("nostb_we", bus.ram_we, 0); chk("nostb_be", bus.ram_be, 0);
    nxt(); smp(); chk("nostb_dtk", bus.cpu_dtack_n, 0);
    nxt(); bus.cpu_sel = 1'b0; smp();
    nxt();
    cpu_read("nostb_rb", AW'('h21), init_val('h21));
    bus.rnd_req = 1'b1; bus.rnd_addr = AW'('h40);
    cpu_start(1'b0, 1'b0, 1'b0, AW'('h123), 16'h0);
    for (int k = 0; k < SM; k++) begin
      smp(); chk($sformatf("stv_ack%0d", k), bus.rnd_ack, 1); chk($sformatf("stv_addr%0d", k), bus.ram_addr, 'h40);
      nxt();
    end
    smp(); chk("stv_grant_ack", bus.rnd_ack, 0); chk("stv_grant_addr", bus.ram_addr, 'h123);
    nxt(); smp(); chk("stv_ack_after", bus.rnd_ack, 1);
    nxt(); smp(); chk("stv_dtk", bus.cpu_dtack_n, 0); chk("stv_data", bus.cpu_dout, 16'hBEEF);
    nxt(); bus.cpu_sel = 1'b0; bus.rnd_req = 1'b0;
    nxt();
    bus.rnd_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.rnd_addr = AW'(c);
      smp(); chk($sformatf("str_ack%0d", c), bus.rnd_ack, 1);
      chk($sformatf("str_valid%0d", c), bus.rnd_valid, c > 0);
      if (c > 0) chk($sformatf("str_data%0d", c - 1), bus.rnd_data, shadow[c - 1]);
      nxt();
    end
    bus.rnd_req = 1'b0;
    smp(); chk("str_valid8", bus.rnd_valid, 1); chk("str_data7", bus.rnd_data, shadow[7]);
    nxt(); smp(); chk("str_valid_end", bus.rnd_valid, 0);
    nxt();
    bus.rnd_req = 1'b1; bus.rnd_addr = AW'('h40);
    cpu_start(1'b1, 1'b0, 1'b0, AW'('h20), 16'h5A5A);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bus.cpu_sel = 1'b0;
      smp(); chk($sformatf("abt_we%0d", k), bus.ram_we, 0); chk($sformatf("abt_dtk%0d", k), bus.cpu_dtack_n, 1);
      chk($sformatf("abt_ack%0d", k), bus.rnd_ack, 1);
      nxt();
    end
    bus.cpu_sel = 1'b1;
    for (int k = 0; k < SM; k++) begin
      smp(); chk($sformatf("abt_re_deny%0d", k), bus.rnd_ack, 1); chk($sformatf("abt_re_we%0d", k), bus.ram_we, 0);
      nxt();
    end
    smp(); chk("abt_re_grant", bus.ram_we, 1); chk("abt_re_addr", bus.ram_addr, 'h20);
    shadow['h20] = 16'h5A5A;
    nxt(); smp(); chk("abt_re_dtk", bus.cpu_dtack_n, 0);
    nxt(); bus.cpu_sel = 1'b0; bus.rnd_req = 1'b0;
    nxt();
    cpu_read("abt_rb", AW'('h20), 16'h5A5A);
    cpu_start(1'b0, 1'b0, 1'b0, AW'('h123), 16'h0);
    smp(); chk("rr_grant", bus.ram_addr, 'h123);
    nxt(); rst = 1'b1; bus.rnd_req = 1'b1;
    smp(); chk("rr_ack_gated", bus.rnd_ack, 0); chk("rr_be_gated", bus.ram_be, 0); chk("rr_we_gated", bus.ram_we, 0);
    nxt(); rst = 1'b0; bus.rnd_req = 1'b0;
    smp(); chk("rr_dtk", bus.cpu_dtack_n, 1); chk("rr_dout", bus.cpu_dout, 0); chk("rr_regrant", bus.ram_addr, 'h123);
    nxt(); smp(); chk("rr_dtk1", bus.cpu_dtack_n, 1);
    nxt(); smp(); chk("rr_dtk2", bus.cpu_dtack_n, 0); chk("rr_data", bus.cpu_dout, 16'hBEEF);
    nxt(); bus.cpu_sel = 1'b0;
    nxt();
    ph = 0; denied = 0; prev_ack = 1'b0; prev_addr = '0; wr = 1'b0; be = '0; ca = '0; cd = '0; exp_dout = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.rnd_req || prev_ack) begin
        bus.rnd_req  = ($urandom % 3) != 0;
        bus.rnd_addr = AW'(32 + $urandom % 32);
      end
      if (ph == 0 && ($urandom % 2) == 1) begin
        wr = 1'(($urandom % 2));
        be = 2'($urandom % 4);
        ca = wr ? AW'($urandom % 32) : AW'($urandom % 64);
        cd = 16'($urandom);
        cpu_start(wr, !be[1], !be[0], ca, cd);
        ph = 1; denied = 0;
      end else if (ph == 3) begin
        bus.cpu_sel = 1'b0;
        ph = 4;
      end
      smp();
      exp_ack = bus.rnd_req;
      grant = 1'b0;
      chk("r_dtk", bus.cpu_dtack_n, !(ph == 3 || ph == 4));
      if (ph == 3 && !wr) chk("r_dout", bus.cpu_dout, exp_dout);
      chk("r_valid", bus.rnd_valid, prev_ack);
      if (prev_ack) chk("r_rdata", bus.rnd_data, shadow[prev_addr]);
      if (ph == 1) begin
        if (!bus.rnd_req || denied >= SM) begin
          grant = 1'b1; exp_ack = 1'b0;
          chk("r_caddr", bus.ram_addr, ca);
          chk("r_cbe", bus.ram_be, be);
          chk("r_cwe", bus.ram_we, wr && be != 0);
          if (wr) begin
            if (be[1]) shadow[ca][15:8] = cd[15:8];
            if (be[0]) shadow[ca][7:0]  = cd[7:0];
            if (wr && be != 0) chk("r_wdata_sel", {16'h0, bus.ram_wdata & {{8{be[1]}}, {8{be[0]}}}}, {16'h0, cd & {{8{be[1]}}, {8{be[0]}}}});
          end
          exp_dout = shadow[ca];
          ph = wr ? 3 : 2;
        end else denied++;
      end else if (ph == 2) ph = 3;
      else if (ph == 4) ph = 0;
      chk("r_ack", bus.rnd_ack, exp_ack);
      if (exp_ack) begin
        chk("r_raddr", bus.ram_addr, bus.rnd_addr);
        chk("r_rbe", bus.ram_be, 2'b11);
        chk("r_rwe", bus.ram_we, 0);
      end else if (!grant) begin
        chk("r_idle_we", bus.ram_we, 0);
        chk("r_idle_be", bus.ram_be, 0);
        chk("r_idle_addr", bus.ram_addr, 0);
      end
      prev_ack = exp_ack;
      prev_addr = bus.rnd_addr;
      nxt();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
